ad_usb_streamer: RTL and testbench
==================================

# ad_usb_streamer

Downstream consumer of the ADC ping-pong cache, running entirely in the cache read clock domain. On each `switch` pulse (a half-buffer is complete), it streams one frame to the USB slave-FIFO write port: a 2-word header followed by `FRAME_WORDS` samples read out of the cache. A small skid FIFO absorbs the cache read latency and USB back-pressure. The block flags, counts and recovers from overruns, where a new half-buffer completes before the current frame has drained.

## Interface
Parameters:
- `DATA_NBIT`, `USB_DATA_NBIT` (16): width of cache read data and of the USB bus.
- `FRAME_WORDS`, `AD_CHE_DATA_SIZE` (1024): 16-bit cache words per half-buffer. Must be a power of 2.
- `RD_LAT`, 2: cycles from an `rd` pulse to its word appearing on `rdata`.
- `SKID_DEPTH`, 4: skid FIFO entries. Must be ≥ `RD_LAT`+1 and a power of 2.
- `SYNC_WORD`, 16'hA55A: header word 0.

Ports:
- Clocking is decided: one clock, `rclk`; reset `rst_n` is asynchronous and active-low.
- `rclk`  in  1  read-domain clock, shared with the cache read port.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  streaming enable.
- `switch`  in  1  one-cycle pulse from the cache: the other half is ready, and the cache read address is zeroed.
- `rd`  out  1  cache read-advance strobe.
- `rdata`  in  `DATA_NBIT`  cache read data.
- `usb_full`  in  1  USB FIFO full, active-high.
- `usb_wr`  out  1  USB data valid.
- `usb_data`  out  `DATA_NBIT`  USB data.
- `usb_pktend`  out  1  one-cycle packet-end strobe.
- `overrun`  out  1  sticky overrun flag. Cleared by reset or by `en` low.
- `frame_cnt`  out  16  frames started since reset, wrapping.

## Operation
- States are `IDLE`, `HDR0`, `HDR1`, `DATA`, `DRAIN` and `PKTEND`.
- `IDLE` to `HDR0`: on `switch` with `en` high.
- `HDR0`: push `SYNC_WORD` into the skid FIFO, then go to `HDR1`.
- `HDR1`: push `frame_cnt`, increment `frame_cnt`, then go to `DATA`. The header therefore carries the pre-increment value.
- `DATA`: pulse `rd` when `skid_count + inflight < SKID_DEPTH`. Count pulses in `rd_cnt`. Go to `DRAIN` after the `FRAME_WORDS`-th pulse.
- `DRAIN`: wait until inflight = 0 and the skid FIFO and output register are empty.
- `PKTEND`: assert `usb_pktend` for one cycle when `usb_full` is low, then go to `IDLE`.
- Pushes in `HDR0`/`HDR1` obey the same credit rule as `rd` pulses.
- Read capture: a valid shift register of length `RD_LAT` tracks `rd` pulses. `rdata` is pushed into the skid FIFO in the cycle where the delayed valid is high. "Inflight" is the popcount of that shift register.
- Output: registered valid/ready.
  - A word transfers in any cycle with `usb_wr`=1 and `usb_full`=0.
  - While `usb_full`=1, `usb_wr` and `usb_data` hold.
  - The output register reloads from the skid FIFO on transfer, or when empty.
- Overrun (`switch` in any state other than `IDLE`):
  - set `overrun`;
  - flush the skid FIFO, the inflight shift register and the output register (`usb_wr` goes to 0 next cycle);
  - clear `rd_cnt`;
  - go to `HDR0`.
  - No `pktend` is issued for the aborted frame; the host detects the truncated frame from the `frame_cnt` gap/sequence.
- `en` low: next cycle go to `IDLE`, flush everything, clear `overrun`, keep `frame_cnt`. A `switch` while `en` is low is ignored.
- `rd` is never asserted in the same cycle as `switch`, because the cache gives `switch` priority. The first `rd` of a frame comes no earlier than the cycle after `HDR1`.

## Timing
- Reset values: `rd`=0, `usb_wr`=0, `usb_data`=0, `usb_pktend`=0, `overrun`=0, `frame_cnt`=0, state `IDLE`, all FIFO pointers, `rd_cnt`=0.
- The n-th `rd` pulse after `switch` (n from 0) in cycle t returns cache word n on `rdata` in cycle t+`RD_LAT`.
- With `usb_full` held at 0:
  - `SYNC_WORD` is on `usb_data`, with `usb_wr` high, 3 cycles after `switch`;
  - data words then follow back-to-back, one per cycle, with no bubbles;
  - `usb_pktend` comes 1 cycle after the last accepted word.
- Frame length on the bus is exactly `FRAME_WORDS`+2 accepted words.
- Widths:
  - `rd_cnt` is log2(`FRAME_WORDS`)+1 bits;
  - `skid_count` is log2(`SKID_DEPTH`)+1 bits;
  - `frame_cnt` wraps from 16'hFFFF to 0.
- The skid FIFO never overflows under the credit rule. Push and pop in the same cycle leaves the count unchanged.

## Structure
- The shared globals header gains `AD_USB_SYNC_WORD` and `AD_USB_FRAME_CNT_NBIT`. It reuses `USB_DATA_NBIT` and `AD_CHE_DATA_SIZE`.
- State encodings are local parameters.
- One sub-module: `skid_fifo`, a synchronous FIFO parameterised by width and depth, with push, pop, flush, count and first-word-fall-through output.

## Test plan
- Basic frame: `FRAME_WORDS`=8, cache model returns address as data, `usb_full`=0, one `switch` → bus shows A55A, 0000, 0..7 consecutively, then one `usb_pktend`, and `frame_cnt`=1.
- Back-pressure: as above, with `usb_full` toggling pseudo-randomly at 50% → same 10-word sequence with no loss or duplication, `usb_data` stable whenever `usb_full`=1, and `skid_count` never exceeds 4.
- Latency sweep: `RD_LAT`=1, 2 and 3 with `SKID_DEPTH`=4 → identical bus sequences; at `RD_LAT`=2 with `usb_full`=0, no output bubbles.
- Overrun: a second `switch` after 5 data words → `overrun`=1, no `pktend`, then a new frame with header A55A, 0001 and data 0..7.
- Enable drop: `en` driven low mid-`DATA` → `usb_wr`=0 and `rd`=0 within 2 cycles, `overrun` cleared, and a later `switch` while `en`=0 is ignored.
- Reset mid-frame: `rst_n` asserted mid-`DATA` → all outputs 0 immediately (asynchronous), and the next frame header carries `frame_cnt` 0000.

Source files
------------

// File: rtl/ad_usb_streamer_pkg.sv
// Shared globals for the ADC cache to USB streaming path.
package ad_usb_streamer_pkg;

    localparam int USB_DATA_NBIT         = 16;
    localparam int AD_CHE_DATA_SIZE      = 1024;
    localparam int AD_USB_FRAME_CNT_NBIT = 16;
    localparam logic [15:0] AD_USB_SYNC_WORD = 16'hA55A;

    // Number of set bits among the low nbits of a vector (nbits <= 32).
    function automatic int ones_count(input logic [31:0] bits, input int nbits);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            if ((i < nbits) && bits[i]) begin
                c = c + 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/ad_usb_streamer_skid_fifo.sv
// Small synchronous FIFO with first-word-fall-through head, flush and occupancy count.
module ad_usb_streamer_skid_fifo
    import ad_usb_streamer_pkg::*;
#(
    parameter int WIDTH = USB_DATA_NBIT,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

    // Pointers and occupancy; flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array, data only, no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ad_usb_streamer.sv
// Streams one header+data frame per cache half-buffer to the USB slave FIFO.
module ad_usb_streamer
    import ad_usb_streamer_pkg::*;
#(
    parameter int DATA_NBIT   = USB_DATA_NBIT,
    parameter int FRAME_WORDS = AD_CHE_DATA_SIZE,
    parameter int RD_LAT      = 2,
    parameter int SKID_DEPTH  = 4,
    parameter logic [DATA_NBIT-1:0] SYNC_WORD = AD_USB_SYNC_WORD
) (
    input  logic                             rclk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic                             switch,
    output logic                             rd,
    input  logic [DATA_NBIT-1:0]             rdata,
    input  logic                             usb_full,
    output logic                             usb_wr,
    output logic [DATA_NBIT-1:0]             usb_data,
    output logic                             usb_pktend,
    output logic                             overrun,
    output logic [AD_USB_FRAME_CNT_NBIT-1:0] frame_cnt
);

    localparam int RC_W = $clog2(FRAME_WORDS) + 1;
    localparam int SC_W = $clog2(SKID_DEPTH) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR0   = 3'd1;
    localparam logic [2:0] S_HDR1   = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_PKTEND = 3'd5;

    logic [2:0]           state;
    logic [RC_W-1:0]      rd_cnt;
    logic [RD_LAT-1:0]    rd_vld_p;
    int                   inflight;
    logic                 credit;
    logic                 flush;
    logic                 hdr_push;
    logic                 cap_push;
    logic                 fifo_push;
    logic [DATA_NBIT-1:0] fifo_din;
    logic                 fifo_pop;
    logic [DATA_NBIT-1:0] fifo_head;
    logic                 fifo_empty;
    logic [SC_W-1:0]      skid_count;
    logic                 out_load;
    logic                 last_rd;
    logic                 drain_done;

    // Words already owed to the skid FIFO plus those still in the cache pipe
    // must leave room for one more, so the FIFO can never overflow.
    assign inflight = ones_count(32'(rd_vld_p), RD_LAT);
    assign credit   = (int'(skid_count) + inflight) < SKID_DEPTH;

    // Disable and any switch (restart or overrun) discard everything in flight.
    assign flush = !en || switch;

    assign hdr_push  = en && !switch && credit && ((state == S_HDR0) || (state == S_HDR1));
    assign cap_push  = rd_vld_p[RD_LAT-1];
    assign fifo_push = hdr_push || cap_push;
    assign fifo_din  = cap_push ? rdata :
                       ((state == S_HDR0) ? SYNC_WORD : DATA_NBIT'(frame_cnt));

    assign rd      = en && !switch && (state == S_DATA) && credit;
    assign last_rd = rd && (rd_cnt == RC_W'(FRAME_WORDS - 1));

    // Output register may take a new word when it is empty or being accepted.
    assign out_load = !usb_wr || !usb_full;
    assign fifo_pop = out_load && !fifo_empty && !flush;

    // Counting the word accepted this cycle as gone lets pktend follow it directly.
    assign drain_done = (inflight == 0) && fifo_empty && out_load;

    assign usb_pktend = (state == S_PKTEND) && !usb_full;

    ad_usb_streamer_skid_fifo #(
        .WIDTH (DATA_NBIT),
        .DEPTH (SKID_DEPTH)
    ) u_skid_fifo (
        .clk       (rclk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (fifo_push),
        .push_data (fifo_din),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (skid_count)
    );

    // Read-valid pipe: mirrors the cache read latency so rdata is captured on time.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_p <= '0;
        end else if (flush) begin
            rd_vld_p <= '0;
        end else begin
            rd_vld_p <= (rd_vld_p << 1) | RD_LAT'(rd);
        end
    end

    // USB output register: holds while the host FIFO is full.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            usb_wr   <= 1'b0;
            usb_data <= '0;
        end else if (flush) begin
            usb_wr   <= 1'b0;
        end else if (out_load) begin
            usb_wr <= !fifo_empty;
            if (!fifo_empty) begin
                usb_data <= fifo_head;
            end
        end
    end

    // Frame sequencer with overrun restart and enable-drop recovery.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rd_cnt    <= '0;
            overrun   <= 1'b0;
            frame_cnt <= '0;
        end else if (!en) begin
            state   <= S_IDLE;
            rd_cnt  <= '0;
            overrun <= 1'b0;
        end else if (switch) begin
            state  <= S_HDR0;
            rd_cnt <= '0;
            if (state != S_IDLE) begin
                overrun <= 1'b1;
            end
        end else begin
            case (state)
                S_HDR0: begin
                    if (credit) begin
                        state <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (credit) begin
                        state     <= S_DATA;
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rd) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (last_rd) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state <= S_PKTEND;
                    end
                end
                S_PKTEND: begin
                    if (!usb_full) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad_usb_streamer.sv
// Bench: three streamers (read latency 1, 2, 3) share stimulus; each has its own cache model.
module tb_ad_usb_streamer;

    localparam int          FW    = 8;
    localparam int          NL    = 3;
    localparam int          DEPTH = 4;
    localparam logic [15:0] SYNC  = 16'hA55A;
    localparam int          MAIN  = 1;

    logic rclk = 1'b0;
    logic rst_n;
    logic en;
    logic switch;
    logic usb_full;

    always #5 rclk = ~rclk;

    logic [15:0] mem [FW];

    logic        rd_a   [NL];
    logic        wr_a   [NL];
    logic        pk_a   [NL];
    logic        ov_a   [NL];
    logic [15:0] data_a [NL];
    logic [15:0] fc_a   [NL];
    logic [2:0]  cnt_a  [NL];

    genvar g;
    for (g = 0; g < NL; g++) begin : lane
        localparam int LAT = g + 1;
        logic        rd;
        logic        usb_wr;
        logic        usb_pktend;
        logic        overrun;
        logic [15:0] rdata;
        logic [15:0] usb_data;
        logic [15:0] frame_cnt;
        logic [15:0] addr = 16'd0;
        logic [15:0] apipe [LAT];

        // Cache read port: address zeroed by switch, advanced by rd, fixed latency.
        always @(posedge rclk) begin
            if (switch) addr <= 16'd0;
            else if (rd) addr <= addr + 16'd1;
            apipe[0] <= addr;
            for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
        end
        assign rdata = mem[apipe[LAT-1][2:0]];

        ad_usb_streamer #(
            .DATA_NBIT   (16),
            .FRAME_WORDS (FW),
            .RD_LAT      (LAT),
            .SKID_DEPTH  (DEPTH),
            .SYNC_WORD   (SYNC)
        ) u_dut (
            .rclk       (rclk),
            .rst_n      (rst_n),
            .en         (en),
            .switch     (switch),
            .rd         (rd),
            .rdata      (rdata),
            .usb_full   (usb_full),
            .usb_wr     (usb_wr),
            .usb_data   (usb_data),
            .usb_pktend (usb_pktend),
            .overrun    (overrun),
            .frame_cnt  (frame_cnt)
        );

        assign rd_a[g]   = rd;
        assign wr_a[g]   = usb_wr;
        assign pk_a[g]   = usb_pktend;
        assign ov_a[g]   = overrun;
        assign data_a[g] = usb_data;
        assign fc_a[g]   = frame_cnt;
        assign cnt_a[g]  = u_dut.u_skid_fifo.count;
    end

    int          cyc = 0;
    logic [15:0] cap    [NL][512];
    int          ccyc   [NL][512];
    int          ncap   [NL] = '{default: 0};
    int          npkt   [NL] = '{default: 0};
    int          pkcyc  [NL] = '{default: 0};
    bit          unstable [NL] = '{default: 1'b0};
    int          maxcnt [NL] = '{default: 0};
    logic        hold_p [NL] = '{default: 1'b0};
    logic [15:0] hold_d [NL];

    // Bus monitor: accepted words, pktend strobes, hold stability, skid occupancy.
    always @(negedge rclk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NL; i++) begin
            if (wr_a[i] === 1'b1 && usb_full === 1'b0 && ncap[i] < 512) begin
                cap[i][ncap[i]]  <= data_a[i];
                ccyc[i][ncap[i]] <= cyc;
                ncap[i]          <= ncap[i] + 1;
            end
            if (pk_a[i] === 1'b1) begin
                npkt[i]  <= npkt[i] + 1;
                pkcyc[i] <= cyc;
            end
            if (hold_p[i] && (wr_a[i] !== 1'b1 || data_a[i] !== hold_d[i])) unstable[i] <= 1'b1;
            hold_p[i] <= (wr_a[i] === 1'b1) && (usb_full === 1'b1) && (rst_n === 1'b1);
            hold_d[i] <= data_a[i];
            if (int'(cnt_a[i]) > maxcnt[i]) maxcnt[i] <= int'(cnt_a[i]);
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int mfc    = 0;
    int st_pkt [NL];
    int st_cap [NL];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < NL; i++) begin
            st_pkt[i] = npkt[i];
            st_cap[i] = ncap[i];
        end
    endtask

    task automatic pulse_switch();
        switch = 1'b1;
        @(posedge rclk); #1;
        switch = 1'b0;
    endtask

    // Wait for one more pktend on every lane, optionally with random back-pressure.
    task automatic wait_pkt(input bit bp, input string tag);
        int  budget;
        bit  done;
        budget = 3000;
        do begin
            @(posedge rclk); #1;
            if (bp) usb_full = 1'($urandom_range(0, 1));
            done = 1'b1;
            for (int i = 0; i < NL; i++) if (npkt[i] < st_pkt[i] + 1) done = 1'b0;
            budget--;
        end while (!done && budget > 0);
        usb_full = 1'b0;
        chk({tag, "_timeout"}, 32'(done), 32'd1);
        repeat (3) @(posedge rclk);
        #1;
    endtask

    // Wait until the main lane has accepted n words of the current frame.
    task automatic wait_words(input int n, input string tag);
        int budget;
        budget = 500;
        while ((ncap[MAIN] - st_cap[MAIN]) < n && budget > 0) begin
            @(posedge rclk); #1;
            budget--;
        end
        chk({tag, "_wait"}, 32'(budget > 0), 32'd1);
    endtask

    task automatic check_frame(input int ln, input int st, input int fc, input string tag);
        logic [15:0] e;
        for (int k = 0; k < FW + 2; k++) begin
            if (k == 0) e = SYNC;
            else if (k == 1) e = 16'(fc);
            else e = mem[k-2];
            chk($sformatf("%s_l%0d_w%0d", tag, ln, k), 32'(cap[ln][st+k]), 32'(e));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("%s_ctl_l%0d", tag, i), 32'({rd_a[i], wr_a[i], pk_a[i], ov_a[i]}), 32'd0);
            chk($sformatf("%s_data_l%0d", tag, i), 32'(data_a[i]), 32'd0);
            chk($sformatf("%s_fcnt_l%0d", tag, i), 32'(fc_a[i]), 32'd0);
        end
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0; en = 1'b0; switch = 1'b0; usb_full = 1'b0;
        for (int k = 0; k < FW; k++) mem[k] = 16'($urandom);

        // Reset state
        repeat (3) @(posedge rclk);
        @(negedge rclk);
        check_outputs_zero("reset");
        @(posedge rclk); #1;
        rst_n = 1'b1; en = 1'b1;
        repeat (2) @(posedge rclk);
        #1;

        // Basic frame, no back-pressure
        snap();
        pulse_switch();
        @(posedge rclk); @(posedge rclk); @(negedge rclk);
        for (int i = 0; i < NL; i++)
            chk($sformatf("sync_at_3_l%0d", i), 32'({wr_a[i], data_a[i]}), 32'({1'b1, SYNC}));
        wait_pkt(1'b0, "basic");
        for (int i = 0; i < NL; i++) begin
            check_frame(i, st_cap[i], mfc, "basic");
            chk($sformatf("basic_len_l%0d", i), 32'(ncap[i] - st_cap[i]), FW + 2);
            chk($sformatf("basic_pkt_l%0d", i), 32'(npkt[i] - st_pkt[i]), 32'd1);
            chk($sformatf("basic_pktend_gap_l%0d", i), 32'(pkcyc[i] - ccyc[i][ncap[i]-1]), 32'd1);
            chk($sformatf("basic_fcnt_l%0d", i), 32'(fc_a[i]), 32'(mfc + 1));
        end
        ok = 1'b1;
        for (int k = 3; k < FW + 2; k++)
            if (ccyc[MAIN][st_cap[MAIN]+k] != ccyc[MAIN][st_cap[MAIN]+k-1] + 1) ok = 1'b0;
        chk("basic_no_bubbles", 32'(ok), 32'd1);
        mfc++;

        // Random back-pressure
        snap();
        pulse_switch();
        wait_pkt(1'b1, "bp");
        for (int i = 0; i < NL; i++) begin
            check_frame(i, st_cap[i], mfc, "bp");
            chk($sformatf("bp_len_l%0d", i), 32'(ncap[i] - st_cap[i]), FW + 2);
            chk($sformatf("bp_pkt_l%0d", i), 32'(npkt[i] - st_pkt[i]), 32'd1);
            chk($sformatf("bp_hold_l%0d", i), 32'(unstable[i]), 32'd0);
            chk($sformatf("bp_skid_max_l%0d", i), 32'(maxcnt[i] <= DEPTH), 32'd1);
            chk($sformatf("bp_fcnt_l%0d", i), 32'(fc_a[i]), 32'(mfc + 1));
        end
        mfc++;

        // Overrun: second switch mid-frame
        snap();
        pulse_switch();
        wait_words(7, "ovr");
        chk("ovr_before", 32'(ov_a[MAIN]), 32'd0);
        pulse_switch();
        mfc++;
        wait_pkt(1'b0, "ovr");
        repeat (20) @(posedge rclk);
        #1;
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("ovr_flag_l%0d", i), 32'(ov_a[i]), 32'd1);
            chk($sformatf("ovr_pkt_l%0d", i), 32'(npkt[i] - st_pkt[i]), 32'd1);
            chk($sformatf("ovr_abort_hdr_l%0d", i), 32'(cap[i][st_cap[i]+1]), 32'(mfc - 1));
            check_frame(i, ncap[i] - (FW + 2), mfc, "ovr_new");
            chk($sformatf("ovr_fcnt_l%0d", i), 32'(fc_a[i]), 32'(mfc + 1));
        end
        mfc++;

        // Enable drop mid-DATA
        snap();
        pulse_switch();
        mfc++;
        wait_words(4, "endrop");
        en = 1'b0;
        @(posedge rclk); @(posedge rclk); @(negedge rclk);
        for (int i = 0; i < NL; i++)
            chk($sformatf("endrop_idle_l%0d", i), 32'({wr_a[i], rd_a[i], ov_a[i]}), 32'd0);
        @(posedge rclk); #1;
        for (int i = 0; i < NL; i++) st_cap[i] = ncap[i];
        pulse_switch();
        repeat (30) @(posedge rclk);
        #1;
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("endrop_ignore_words_l%0d", i), 32'(ncap[i] - st_cap[i]), 32'd0);
            chk($sformatf("endrop_no_pkt_l%0d", i), 32'(npkt[i] - st_pkt[i]), 32'd0);
            chk($sformatf("endrop_fcnt_l%0d", i), 32'(fc_a[i]), 32'(mfc));
        end
        en = 1'b1;
        repeat (2) @(posedge rclk);
        #1;
        snap();
        pulse_switch();
        wait_pkt(1'b0, "reen");
        for (int i = 0; i < NL; i++) begin
            check_frame(i, st_cap[i], mfc, "reen");
            chk($sformatf("reen_ovr_l%0d", i), 32'(ov_a[i]), 32'd0);
        end
        mfc++;

        // Asynchronous reset mid-DATA
        snap();
        pulse_switch();
        wait_words(4, "rstmid");
        #3 rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_async");
        repeat (2) @(posedge rclk);
        #1 rst_n = 1'b1;
        mfc = 0;
        repeat (2) @(posedge rclk);
        #1;
        snap();
        pulse_switch();
        wait_pkt(1'b0, "postrst");
        for (int i = 0; i < NL; i++) begin
            check_frame(i, st_cap[i], mfc, "postrst");
            chk($sformatf("postrst_fcnt_l%0d", i), 32'(fc_a[i]), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
